// File: rtl/cmos_arb_pkg.sv
// Shared types and constants for the dual-camera burst arbiter.
package cmos_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam logic CH_CMOS1 = 1'b0;
  localparam logic CH_CMOS2 = 1'b1;

  // Ceiling log2, used to size the beat counter from BURST_LEN.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmos_frame_tracker.sv
// Per-channel frame bookkeeping: counts frame-start pulses and keeps a
// start-of-frame pending flag until the first beat of the next burst.
module cmos_frame_tracker (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start_i,
  input  logic        sof_clr_i,
  output logic [15:0] frame_cnt_o,
  output logic        sof_pend_o
);

  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        sof_pend_q, sof_pend_d;

  // Next state: a new frame start beats a same-cycle clear so the flag
  // survives into the following burst.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    sof_pend_d  = sof_pend_q;
    if (frame_start_i) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      sof_pend_d  = 1'b1;
    end else if (sof_clr_i) begin
      sof_pend_d  = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      sof_pend_q  <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      sof_pend_q  <= sof_pend_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign sof_pend_o  = sof_pend_q;

endmodule

// File: rtl/cmos_dual_burst_arb.sv
// Round-robin arbiter granting whole bursts from two camera FIFOs onto one
// valid/ready stream, tagged with channel, start-of-frame and last-beat.
module cmos_dual_burst_arb
  import cmos_arb_pkg::*;
#(
  parameter int DW        = 16,
  parameter int BURST_LEN = 16,
  parameter int LVL_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ch_en,
  input  logic             ch0_frame_start,
  input  logic [LVL_W-1:0] ch0_rd_cnt,
  input  logic [DW-1:0]    ch0_rd_data,
  output logic             ch0_rd_en,
  input  logic             ch1_frame_start,
  input  logic [LVL_W-1:0] ch1_rd_cnt,
  input  logic [DW-1:0]    ch1_rd_data,
  output logic             ch1_rd_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_ch,
  output logic             out_sof,
  output logic             out_last,
  output logic             busy,
  output logic [15:0]      ch0_frame_cnt,
  output logic [15:0]      ch1_frame_cnt
);

  localparam int              BW        = clog2(BURST_LEN);
  localparam logic [LVL_W-1:0] BURST_THR = LVL_W'(BURST_LEN);
  localparam logic [BW-1:0]    LAST_BEAT = BW'(BURST_LEN - 1);

  arb_state_e      state_q, state_d;
  logic            out_ch_q, out_ch_d;
  logic            last_grant_q, last_grant_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

  logic [1:0]       eligible;
  logic [1:0]       frame_start;
  logic [1:0]       sof_pend;
  logic [1:0]       sof_clr;
  logic [1:0][15:0] frame_cnt;
  logic             grant;
  logic             first_beat;

  assign eligible[CH_CMOS1] = ch_en[CH_CMOS1] & (ch0_rd_cnt >= BURST_THR);
  assign eligible[CH_CMOS2] = ch_en[CH_CMOS2] & (ch1_rd_cnt >= BURST_THR);

  // On a tie the channel that did not win last time gets the grant.
  assign grant = (&eligible) ? ~last_grant_q : eligible[CH_CMOS2];

  assign busy       = (state_q == BURST);
  assign first_beat = busy & (beat_cnt_q == '0);
  assign out_ch     = out_ch_q;
  assign out_data   = out_ch_q ? ch1_rd_data : ch0_rd_data;
  assign out_sof    = sof_pend[out_ch_q] & first_beat;

  assign frame_start = {ch1_frame_start, ch0_frame_start};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_trk
      assign sof_clr[gi] = first_beat & out_ready & (out_ch_q == 1'(gi));
      cmos_frame_tracker u_trk (
        .clk           (clk),
        .rst           (rst),
        .frame_start_i (frame_start[gi]),
        .sof_clr_i     (sof_clr[gi]),
        .frame_cnt_o   (frame_cnt[gi]),
        .sof_pend_o    (sof_pend[gi])
      );
    end
  endgenerate

  assign ch0_frame_cnt = frame_cnt[CH_CMOS1];
  assign ch1_frame_cnt = frame_cnt[CH_CMOS2];

  // Grant selection in IDLE, beat handshake and burst termination in BURST.
  always_comb begin
    state_d      = state_q;
    out_ch_d     = out_ch_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    ch0_rd_en    = 1'b0;
    ch1_rd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          out_ch_d     = grant;
          last_grant_d = grant;
          beat_cnt_d   = '0;
          state_d      = BURST;
        end
      end
      BURST: begin
        out_valid = 1'b1;
        out_last  = (beat_cnt_q == LAST_BEAT);
        if (out_ch_q) ch1_rd_en = out_ready;
        else          ch0_rd_en = out_ready;
        if (out_ready) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (out_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state; reset makes ch0 the winner of the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      out_ch_q     <= CH_CMOS1;
      last_grant_q <= CH_CMOS2;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      out_ch_q     <= out_ch_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule
